// File: rtl/stream_capture_pkg.sv
// Shared types and helpers for the triggered stream capture stage.
package stream_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int unsigned TS_WIDTH = 64;

    // Record length: zero or anything beyond the BRAM depth means a full-depth record
    function automatic int unsigned clamp_len(input int unsigned n, input int unsigned depth);
        return ((n == 0) || (n > depth)) ? depth : n;
    endfunction

endpackage

// File: rtl/stream_capture_edge_detect.sv
// Rising-edge detector with one cycle of registered history.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic prev;

    // History follows the input even while in reset, so a level held high across reset is not an edge
    always_ff @(posedge clk) begin
        prev <= din;
    end

    assign rise = din & ~prev & ~rst;

endmodule

// File: rtl/stream_capture.sv
// Triggered acquisition stage: arm, wait for trigger, write a fixed-length record to a BRAM write port.
// Optional feature macro: STREAM_CAPTURE_TIMESTAMP_EN adds trig_time and a free-running cycle counter.
module stream_capture
    import stream_capture_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clken,
    input  logic [WIDTH-1:0]      din,
    input  logic                  arm,
    input  logic                  trig,
    input  logic [ADDR_WIDTH:0]   n_samples,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [WIDTH-1:0]      bram_wdata,
    output logic                  bram_we,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   count
`ifdef STREAM_CAPTURE_TIMESTAMP_EN
    ,
    output logic [TS_WIDTH-1:0]   trig_time
`endif
);

    localparam int unsigned CW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    state_t        state;
    logic [CW-1:0] len;
    logic          trig_pend;
    logic          arm_p;
    logic          trig_p;
    logic          start;
    logic          take;
    logic          last;

    edge_detect u_arm_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (arm),
        .rise (arm_p)
    );

    edge_detect u_trig_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (trig),
        .rise (trig_p)
    );

    // A sample is accepted on clken once triggered (or while already capturing)
    assign start = (state == ARMED) && clken && (trig_p || trig_pend);
    assign take  = start || ((state == CAPTURE) && clken);
    assign last  = (count + CW'(1)) == len;

    // Capture FSM with registered BRAM write port and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            len        <= '0;
            trig_pend  <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
            bram_we    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            count      <= '0;
        end else begin
            bram_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (arm_p) begin
                        state     <= ARMED;
                        len       <= CW'(clamp_len(32'(n_samples), DEPTH));
                        count     <= '0;
                        bram_addr <= '0;
                        trig_pend <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                ARMED: begin
                    if (!start && trig_p) begin
                        trig_pend <= 1'b1;
                    end
                end
                CAPTURE: begin
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (take) begin
                bram_we    <= 1'b1;
                bram_wdata <= din;
                bram_addr  <= count[ADDR_WIDTH-1:0];
                count      <= count + CW'(1);
                trig_pend  <= 1'b0;
                if (last) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state <= CAPTURE;
                end
            end
        end
    end

`ifdef STREAM_CAPTURE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] cycle_cnt;

    // Free-running cycle counter; the trigger cycle's count is latched when capture starts
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            trig_time <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + TS_WIDTH'(1);
            if (start) begin
                trig_time <= cycle_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_capture.sv
// Self-checking bench for stream_capture (ADDR_WIDTH=4): vector table, directed corner cases, random vs model.
module tb_stream_capture;

    localparam int unsigned W     = 32;
    localparam int unsigned AW    = 4;
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clken = 1'b0;
    logic [W-1:0]  din = '0;
    logic          arm = 1'b0;
    logic          trig = 1'b0;
    logic [CW-1:0] n_samples = '0;
    logic [AW-1:0] bram_addr;
    logic [W-1:0]  bram_wdata;
    logic          bram_we;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
`ifdef STREAM_CAPTURE_TIMESTAMP_EN
    logic [63:0]   trig_time;
`endif

    always #5 clk = ~clk;

    stream_capture #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .clken      (clken),
        .din        (din),
        .arm        (arm),
        .trig       (trig),
        .n_samples  (n_samples),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_we    (bram_we),
        .busy       (busy),
        .done       (done),
        .count      (count)
`ifdef STREAM_CAPTURE_TIMESTAMP_EN
        ,
        .trig_time  (trig_time)
`endif
    );

    int tests = 0;
    int fails = 0;
    int nwr   = 0;
    int maxaddr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef enum int {PH_IDLE, PH_WAIT, PH_REC, PH_FIN} phase_t;
    phase_t          m_ph = PH_IDLE;
    bit              m_pend, m_we, m_busy, m_done, m_pa, m_pt;
    int              m_len, m_cnt, m_addr;
    logic [W-1:0]    m_data;
    longint unsigned m_cyc, m_ts;

    task automatic model_clock(input bit r, input bit ce, input bit a, input bit t,
                               input logic [W-1:0] d, input int n);
        bit ap, tp, st, tk;
        ap = a && !m_pa;
        tp = t && !m_pt;
        m_pa = a;
        m_pt = t;
        m_we = 0;
        if (r) begin
            m_ph = PH_IDLE; m_pend = 0; m_cnt = 0; m_addr = 0; m_data = '0;
            m_busy = 0; m_done = 0; m_cyc = 0; m_ts = 0;
            return;
        end
        st = (m_ph == PH_WAIT) && ce && (tp || m_pend);
        tk = st || ((m_ph == PH_REC) && ce);
        if (st) m_ts = m_cyc;
        m_cyc++;
        if ((m_ph == PH_IDLE || m_ph == PH_FIN) && ap) begin
            m_ph = PH_WAIT;
            m_len = (n == 0 || n > DEPTH) ? DEPTH : n;
            m_cnt = 0; m_addr = 0; m_pend = 0; m_busy = 1; m_done = 0;
        end else if (m_ph == PH_WAIT && !st && tp) begin
            m_pend = 1;
        end
        if (tk) begin
            m_we = 1; m_data = d; m_addr = m_cnt; m_cnt++; m_pend = 0;
            if (m_cnt == m_len) begin
                m_ph = PH_FIN; m_done = 1; m_busy = 0;
            end else begin
                m_ph = PH_REC;
            end
        end
    endtask

    // Drive one cycle of inputs, advance model, sample #1 after the edge
    task automatic apply(input bit r, input bit ce, input bit a, input bit t,
                         input logic [W-1:0] d, input int n);
        rst = r; clken = ce; arm = a; trig = t; din = d; n_samples = CW'(n);
        @(posedge clk);
        model_clock(r, ce, a, t, d, n);
        #1;
        if (bram_we === 1'b1) begin
            nwr++;
            if (int'(bram_addr) > maxaddr) maxaddr = int'(bram_addr);
        end
    endtask

    task automatic check_model();
        chk("bram_we", bram_we, m_we);
        chk("bram_addr", bram_addr, m_addr);
        chk("bram_wdata", bram_wdata, m_data);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("count", count, m_cnt);
`ifdef STREAM_CAPTURE_TIMESTAMP_EN
        chk("trig_time", trig_time, m_ts);
`endif
    endtask

    task automatic cyc(input bit r, input bit ce, input bit a, input bit t,
                       input logic [W-1:0] d, input int n);
        apply(r, ce, a, t, d, n);
        check_model();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit           r, ce, a, t;
        logic [W-1:0] d;
        int           n;
        bit           we;
        int           addr;
        logic [W-1:0] wdata;
        bit           bsy, dn;
        int           cnt;
    } vec_t;

    function automatic vec_t mk(bit r, bit ce, bit a, bit t, int d, int n,
                                bit we, int addr, int wdata, bit bsy, bit dn, int cnt);
        vec_t v;
        v.r = r; v.ce = ce; v.a = a; v.t = t; v.d = W'(d); v.n = n;
        v.we = we; v.addr = addr; v.wdata = W'(wdata); v.bsy = bsy; v.dn = dn; v.cnt = cnt;
        return v;
    endfunction

    vec_t vt[12];

    initial begin
        vt[0]  = mk(1, 1, 0, 0,   0, 5,  0, 0,   0, 0, 0, 0);
        vt[1]  = mk(0, 1, 1, 0, 100, 5,  0, 0,   0, 1, 0, 0);
        vt[2]  = mk(0, 1, 1, 0, 101, 5,  0, 0,   0, 1, 0, 0);
        vt[3]  = mk(0, 1, 0, 0, 102, 5,  0, 0,   0, 1, 0, 0);
        vt[4]  = mk(0, 1, 0, 1, 103, 5,  1, 0, 103, 1, 0, 1);
        vt[5]  = mk(0, 1, 0, 1, 104, 5,  1, 1, 104, 1, 0, 2);
        vt[6]  = mk(0, 1, 0, 1, 105, 5,  1, 2, 105, 1, 0, 3);
        vt[7]  = mk(0, 1, 0, 1, 106, 5,  1, 3, 106, 1, 0, 4);
        vt[8]  = mk(0, 1, 0, 1, 107, 5,  1, 4, 107, 0, 1, 5);
        vt[9]  = mk(0, 1, 0, 0, 108, 5,  0, 4, 107, 0, 1, 5);
        vt[10] = mk(0, 1, 0, 1, 109, 5,  0, 4, 107, 0, 1, 5);
        vt[11] = mk(0, 1, 0, 0, 110, 5,  0, 4, 107, 0, 1, 5);

        // Basic record from the table
        for (int i = 0; i < 12; i++) begin
            apply(vt[i].r, vt[i].ce, vt[i].a, vt[i].t, vt[i].d, vt[i].n);
            chk($sformatf("tbl%0d_we", i), bram_we, vt[i].we);
            chk($sformatf("tbl%0d_addr", i), bram_addr, vt[i].addr);
            chk($sformatf("tbl%0d_wdata", i), bram_wdata, vt[i].wdata);
            chk($sformatf("tbl%0d_busy", i), busy, vt[i].bsy);
            chk($sformatf("tbl%0d_done", i), done, vt[i].dn);
            chk($sformatf("tbl%0d_count", i), count, vt[i].cnt);
        end

        // Gapped clken: trig edge lands on a gap and is held pending
        cyc(0, 0, 1, 0, 0, 3);
        nwr = 0;
        for (int i = 0; i < 15; i++) cyc(0, (i % 3) == 2, 0, 1, W'(200 + i), 3);
        chk("gap_writes", nwr, 3);
        chk("gap_done", done, 1);

        // Length clamp: 0 and 31 both give full-depth records
        for (int k = 0; k < 2; k++) begin
            int n;
            n = (k == 0) ? 0 : 31;
            cyc(0, 1, 0, 0, 0, n);
            cyc(0, 1, 1, 0, 0, n);
            cyc(0, 1, 0, 0, 0, n);
            nwr = 0; maxaddr = 0;
            for (int i = 0; i < 20; i++) cyc(0, 1, 0, 1, W'(300 + i), n);
            chk($sformatf("clamp%0d_writes", n), nwr, 16);
            chk($sformatf("clamp%0d_maxaddr", n), maxaddr, 15);
            chk($sformatf("clamp%0d_done", n), done, 1);
            chk($sformatf("clamp%0d_count", n), count, 16);
        end

        // Ignored events: trig before arm, arm+trig together, arm during capture
        cyc(1, 0, 0, 0, 0, 4);
        nwr = 0;
        cyc(0, 1, 0, 1, 0, 4);
        cyc(0, 1, 0, 0, 0, 4);
        chk("trig_before_arm_busy", busy, 0);
        cyc(0, 1, 1, 1, 0, 4);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 1, W'(400 + i), 4);
        chk("arm_trig_same_writes", nwr, 0);
        chk("arm_trig_same_busy", busy, 1);
        cyc(0, 1, 0, 0, 0, 4);
        cyc(0, 1, 0, 1, 500, 4);
        cyc(0, 1, 1, 1, 501, 7);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 1, W'(502 + i), 7);
        chk("arm_in_capture_writes", nwr, 4);
        chk("arm_in_capture_count", count, 4);

        // Reset mid-capture; trig held high across reset must not retrigger
        cyc(0, 1, 1, 0, 0, 8);
        nwr = 0;
        for (int i = 0; i < 12 && nwr < 2; i++) cyc(0, 1, 0, 1, W'(600 + i), 8);
        chk("pre_reset_writes", nwr, 2);
        cyc(1, 1, 0, 1, 0, 8);
        chk("reset_we", bram_we, 0);
        chk("reset_count", count, 0);
        chk("reset_busy", busy, 0);
        cyc(0, 1, 1, 1, 0, 8);
        cyc(0, 1, 0, 1, 0, 8);
        chk("no_edge_across_reset", bram_we, 0);
        cyc(0, 1, 0, 0, 0, 8);
        nwr = 0;
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 1, W'(700 + i), 8);
        chk("rearm_writes", nwr, 8);
        chk("rearm_done", done, 1);

`ifdef STREAM_CAPTURE_TIMESTAMP_EN
        // Timestamp of trigger at cycle 1234 after reset
        cyc(1, 0, 0, 0, 0, 3);
        cyc(0, 0, 1, 0, 0, 3);
        for (int i = 0; i < 2000 && m_cyc != 1234; i++) apply(0, 0, 0, 0, 0, 3);
        cyc(0, 1, 0, 1, 900, 3);
        chk("ts_1234", trig_time, 1234);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, W'(901 + i), 3);
        chk("ts_held", trig_time, 1234);
        cyc(0, 1, 1, 0, 0, 3);
        cyc(0, 1, 0, 1, 0, 3);
        chk("ts_updated", trig_time, m_ts);
        chk("ts_new", (trig_time != 64'd1234), 1);
`endif

        // Random stimulus against the model
        begin
            bit ra, rt, rr, rce;
            ra = 0; rt = 0;
            for (int i = 0; i < 4000; i++) begin
                rr  = ($urandom_range(299) == 0);
                rce = ($urandom_range(3) != 0);
                if ($urandom_range(9) == 0) ra = !ra;
                if ($urandom_range(5) == 0) rt = !rt;
                cyc(rr, rce, ra, rt, W'($urandom), int'($urandom_range(31)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
